// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   arb_state_e : arbiter FSM encoding (ARB_IDLE, ARB_OWN)
//   REQ_*       : fixed requester indices on the shared RAM port
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DMA = 1;
    localparam int unsigned REQ_DBG = 2;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the shared data-RAM port.
//   req/req_we/req_addr/req_wdata : per-requester access request (packed, index i at i*W)
//   gnt/rvalid/rdata              : per-requester grant and read return
//   ram_we/ram_re/ram_addr/ram_wdata/ram_rdata : single-port RAM connection
// Modports:
//   slave  - the arbiter (accepts requests, drives the RAM)
//   master - the environment (requesters and RAM instance)
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      ram_we;
    logic                      ram_re;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_wdata;
    logic [DATA_W-1:0]         ram_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, ram_rdata,
        output gnt, rvalid, rdata, ram_we, ram_re, ram_addr, ram_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, ram_rdata,
        input  gnt, rvalid, rdata, ram_we, ram_re, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector
//   ptr     : highest-priority index this round (must be < N)
//   win_oh  : one-hot winner (zero when nothing requests)
//   win_idx : winner index
//   any     : at least one request present
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    always_comb begin
        int unsigned idx;
        logic [IW-1:0] sel;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        sel     = '0;
        // Scan from ptr upward, wrapping N-1 -> 0; first hit wins.
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!any && req[sel]) begin
                any         = 1'b1;
                win_oh[sel] = 1'b1;
                win_idx     = sel;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM between NUM_REQ requesters (CPU=0, DMA=1, debug=2).
// Round-robin ownership with a burst limit; the owner keeps the port across back-to-back
// accesses and one idle cycle separates successive owners. Read data returns one cycle
// after the read to the requester that issued it.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : mem_port_arbiter_if.slave (requests, grants, read return, RAM port)
//   owner        : current owner index (debug)
// Build option MEM_ARB_CPU_PRIO_EN: CPU wins every arbitration, is exempt from the burst
// limit, and preempts any other owner after that owner's current access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned OwnerW   = $clog2(NUM_REQ),
    localparam int unsigned CntW     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic [OwnerW-1:0] owner
);

    arb_state_e          state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]  owner_oh_q, owner_oh_d;
    logic [OwnerW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [OwnerW-1:0]   pick_idx;
    logic                pick_any;
    logic [NUM_REQ-1:0]  win_oh;
    logic [OwnerW-1:0]   win_idx;

    logic                own_req;
    logic                own_we;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic                issue;
    logic                others;
    logic                limit_hit;
    logic                preempt;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (OwnerW)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Owner's request fields and release conditions.
    always_comb begin
        own_req   = bus.req[owner_q];
        own_we    = bus.req_we[owner_q];
        own_addr  = bus.req_addr[32'(owner_q) * ADDR_W +: ADDR_W];
        own_wdata = bus.req_wdata[32'(owner_q) * DATA_W +: DATA_W];
        issue     = (state_q == ARB_OWN) && own_req;
        others    = |(bus.req & ~owner_oh_q);
`ifdef MEM_ARB_CPU_PRIO_EN
        win_oh    = bus.req[REQ_CPU] ? NUM_REQ'(1) : pick_oh;
        win_idx   = bus.req[REQ_CPU] ? OwnerW'(REQ_CPU) : pick_idx;
        // Burst limit compares the pre-increment count, so it also fires once saturated.
        limit_hit = (owner_q != OwnerW'(REQ_CPU)) && (burst_q >= CntW'(MAX_BURST - 1)) && others;
        preempt   = (owner_q != OwnerW'(REQ_CPU)) && bus.req[REQ_CPU];
`else
        win_oh    = pick_oh;
        win_idx   = pick_idx;
        limit_hit = (burst_q >= CntW'(MAX_BURST - 1)) && others;
        preempt   = 1'b0;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        rr_ptr_d   = rr_ptr_q;
        burst_d    = burst_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_OWN;
                    owner_d    = win_idx;
                    owner_oh_d = win_oh;
                    burst_d    = '0;
                end
            end
            ARB_OWN: begin
                if (issue && (burst_q != CntW'(MAX_BURST))) begin
                    burst_d = burst_q + 1'b1;
                end
                if (!own_req || (issue && (limit_hit || preempt))) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = OwnerW'(wrap_inc(32'(owner_q), NUM_REQ));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A read issued now returns next cycle to the requester registered here, even if
    // ownership has moved on by then.
    assign rvalid_d = (issue && !own_we) ? owner_oh_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            owner_oh_q <= NUM_REQ'(1);
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            rvalid_q   <= rvalid_d;
            if (issue) begin
                addr_q  <= own_addr;
                wdata_q <= own_wdata;
            end
        end
    end

    assign bus.gnt       = (state_q == ARB_OWN) ? (owner_oh_q & bus.req) : '0;
    assign bus.ram_we    = issue & own_we;
    assign bus.ram_re    = issue & ~own_we;
    // Address/data hold their last issued value when no access is issued.
    assign bus.ram_addr  = issue ? own_addr : addr_q;
    assign bus.ram_wdata = issue ? own_wdata : wdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (|rvalid_q) ? bus.ram_rdata : '0;
    assign owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] owner;

    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a + 8'h4A;
    endfunction

    // RAM instance: synchronous read, data valid the cycle after ram_re.
    bit [7:0] ram [256];
    bit       written [256];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr]     <= bus.ram_wdata;
            written[bus.ram_addr] <= 1'b1;
        end
        if (bus.ram_re) begin
            bus.ram_rdata <= written[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
        end
    end

    // Reference model: who owns the port (-1 = nobody), accesses in this tenure,
    // round-robin start point, pending read return, last driven address/data.
    int         m_owner, m_ptr, m_cnt, m_disp, m_rd_who;
    logic [7:0] m_rd_data, m_last_addr, m_last_wdata;
    logic [7:0] ref_mem [256];
    logic [N-1:0] m_gnt;
    int         n_cmp, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_disp = 0; m_rd_who = -1;
        m_rd_data = '0; m_last_addr = '0; m_last_wdata = '0; m_gnt = '0;
    endtask

    function automatic int pick(input logic [N-1:0] rq);
`ifdef MEM_ARB_CPU_PRIO_EN
        if (rq[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at the falling edge: compare outputs, then advance to the next cycle.
    task automatic model_step();
        logic [N-1:0] rq;
        logic         issue, we, rel, others;
        logic [7:0]   a, wd;
        rq = bus.req;
        if (!reset_n) begin
            chk("rst_gnt", 32'(bus.gnt), 0);
            chk("rst_rvalid", 32'(bus.rvalid), 0);
            chk("rst_ram_we", 32'(bus.ram_we), 0);
            chk("rst_ram_re", 32'(bus.ram_re), 0);
            chk("rst_ram_addr", 32'(bus.ram_addr), 0);
            chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
            chk("rst_rdata", 32'(bus.rdata), 0);
            chk("rst_owner", 32'(owner), 0);
            m_gnt = '0;
            return;
        end
        issue = 1'b0; we = 1'b0; a = '0; wd = '0; m_gnt = '0;
        if (m_owner >= 0 && rq[m_owner]) begin
            issue = 1'b1;
            we    = bus.req_we[m_owner];
            a     = bus.req_addr[m_owner*AW +: AW];
            wd    = bus.req_wdata[m_owner*DW +: DW];
            m_gnt[m_owner] = 1'b1;
        end
        chk("gnt", 32'(bus.gnt), 32'(m_gnt));
        chk("ram_we", 32'(bus.ram_we), 32'(issue & we));
        chk("ram_re", 32'(bus.ram_re), 32'(issue & ~we));
        chk("ram_addr", 32'(bus.ram_addr), 32'(issue ? a : m_last_addr));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(issue ? wd : m_last_wdata));
        chk("rvalid", 32'(bus.rvalid), (m_rd_who >= 0) ? (32'd1 << m_rd_who) : 32'd0);
        if (m_rd_who >= 0) chk("rdata", 32'(bus.rdata), 32'(m_rd_data));
        chk("owner", 32'(owner), 32'(m_disp));

        m_rd_who = -1;
        if (issue) begin
            m_last_addr  = a;
            m_last_wdata = wd;
            if (we) ref_mem[a] = wd;
            else begin
                m_rd_who  = m_owner;
                m_rd_data = ref_mem[a];
            end
        end
        if (m_owner < 0) begin
            if (rq != '0) begin
                m_owner = pick(rq);
                m_disp  = m_owner;
                m_cnt   = 0;
            end
        end else begin
            others = (rq & ~(N'(1) << m_owner)) != '0;
            rel    = !rq[m_owner];
            if (issue) begin
                m_cnt++;
`ifdef MEM_ARB_CPU_PRIO_EN
                if (m_owner != 0 && rq[0]) rel = 1'b1;
                else if (m_owner != 0 && m_cnt >= MB && others) rel = 1'b1;
`else
                if (m_cnt >= MB && others) rel = 1'b1;
`endif
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_step();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] wd);
        bus.req[i]               = 1'b1;
        bus.req_we[i]            = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    // Wait (bounded) for requester i to be granted; optionally drop its request after.
    task automatic wait_gnt(input int i, input bit drop, input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            half();
            if (bus.gnt[i]) got = 1'b1;
            fin();
        end
        chk(tag, 32'(got), 1);
        if (drop) bus.req[i] = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] granted;
        n_cmp = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        model_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Single read by DMA: bubble, grant, then data.
        set_req(1, 1'b0, 8'h10, 8'h00);
        half(); chk("rd1_bubble", 32'(bus.gnt), 0); fin();
        half(); chk("rd1_gnt", 32'(bus.gnt), 32'b010); fin();
        bus.req[1] = 1'b0;
        half();
        chk("rd1_rvalid", 32'(bus.rvalid), 32'b010);
        chk("rd1_rdata", 32'(bus.rdata), 32'h5A);
        fin();
        repeat (2) tick();

        // Solo owner keeps the port.
        set_req(2, 1'b0, 8'h33, 8'h00);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            half();
            if (bus.gnt[2]) cnt++;
            fin();
        end
        chk("solo_gnt_cycles", 32'(cnt), 19);
        bus.req[2] = 1'b0;
        repeat (3) tick();

        // All three requesting: 4-access tenures with one bubble, order 0,1,2,0.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h40 + i), 8'(8'hC0 + i));
        for (int c = 0; c < 20; c++) begin
            half();
            chk("rr_gnt", 32'(bus.gnt), (c % 5 == 0) ? 32'd0 : (32'd1 << ((c / 5) % 3)));
            fin();
        end
        bus.req = '0;
        repeat (3) tick();

        // CPU writes, debug reads back the same location.
        set_req(0, 1'b1, 8'h20, 8'hA3);
        wait_gnt(0, 1'b1, "wr_gnt_seen");
        set_req(2, 1'b0, 8'h20, 8'h00);
        wait_gnt(2, 1'b1, "rd_gnt_seen");
        half();
        chk("wr_rd_rvalid", 32'(bus.rvalid), 32'b100);
        chk("wr_rd_rdata", 32'(bus.rdata), 32'hA3);
        fin();
        repeat (2) tick();

        // Reset during a DMA read burst.
        set_req(1, 1'b0, 8'h05, 8'h00);
        wait_gnt(1, 1'b0, "rst_gnt_seen");
        reset_n = 1'b0;
        #1;
        chk("rst_now_gnt", 32'(bus.gnt), 0);
        chk("rst_now_rvalid", 32'(bus.rvalid), 0);
        chk("rst_now_ram_re", 32'(bus.ram_re), 0);
        model_reset();
        fin();
        repeat (2) tick();
        reset_n = 1'b1;
        half(); chk("rst_idle_gnt", 32'(bus.gnt), 0); fin();
        half(); chk("rst_regnt", 32'(bus.gnt), 32'b010); fin();
        bus.req[1] = 1'b0;
        repeat (3) tick();

`ifdef MEM_ARB_CPU_PRIO_EN
        // CPU preempts a DMA burst after its current access.
        set_req(1, 1'b0, 8'h07, 8'h00);
        wait_gnt(1, 1'b0, "pre_dma_gnt");
        set_req(0, 1'b1, 8'h60, 8'h11);
        half(); chk("pre_last_dma", 32'(bus.gnt), 32'b010); fin();
        half(); chk("pre_bubble", 32'(bus.gnt), 0); fin();
        half(); chk("pre_cpu_gnt", 32'(bus.gnt), 32'b001); fin();
        bus.req = '0;
        repeat (3) tick();
`endif

        // Random traffic; requests hold until granted, addresses in a small window.
        for (int c = 0; c < 600; c++) begin
            half();
            granted = m_gnt;
            fin();
            if (c == 300) begin
                reset_n = 1'b0;
                model_reset();
            end
            if (c == 302) reset_n = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (granted[i]) begin
                        if ($urandom_range(0, 2) == 0) bus.req[i] = 1'b0;
                        else set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                                     8'($urandom));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                end
            end
        end
        bus.req = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
